// File: rtl/arithmetic_logic_unit_pkg.sv
// Shared RV32I opcode and ALU op encodings, plus the combinational ALU
// function used by the execution unit.
package arithmetic_logic_unit_pkg;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b1000;
    localparam logic [3:0] OP_SLL  = 4'b0001;
    localparam logic [3:0] OP_SLT  = 4'b0010;
    localparam logic [3:0] OP_SLTU = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_SRA  = 4'b1101;
    localparam logic [3:0] OP_OR   = 4'b0110;
    localparam logic [3:0] OP_AND  = 4'b0111;

    localparam logic [2:0] BR_EQ  = 3'b000;
    localparam logic [2:0] BR_NE  = 3'b001;
    localparam logic [2:0] BR_LT  = 3'b100;
    localparam logic [2:0] BR_GE  = 3'b101;
    localparam logic [2:0] BR_LTU = 3'b110;
    localparam logic [2:0] BR_GEU = 3'b111;

    localparam int ROB_W   = 5;
    localparam int XLEN    = 32;
    localparam int ENTRY_W = ROB_W + XLEN;

    function automatic logic [31:0] alu_compute(
        input logic [6:0]  typ,
        input logic [3:0]  op,
        input logic [31:0] a,
        input logic [31:0] b
    );
        logic [3:0]  eff;
        logic [4:0]  sh;
        logic [31:0] r;
        eff = op;
        sh  = b[4:0];
        r   = a + b;
        // Immediate forms carry imm bits in op[3]; only srai/srli use it.
        if (typ == OPC_I && op[2:0] != 3'b101)
            eff = {1'b0, op[2:0]};
        if (typ == OPC_R || typ == OPC_I) begin
            case (eff)
                OP_SUB:  r = a - b;
                OP_SLL:  r = a << sh;
                OP_SLT:  r = {31'd0, $signed(a) < $signed(b)};
                OP_SLTU: r = {31'd0, a < b};
                OP_XOR:  r = a ^ b;
                OP_SRL:  r = a >> sh;
                OP_SRA:  r = $signed(a) >>> sh;
                OP_OR:   r = a | b;
                OP_AND:  r = a & b;
                default: r = a + b;
            endcase
        end else if (typ == OPC_BRANCH) begin
            case (op[2:0])
                BR_EQ:   r = {31'd0, a == b};
                BR_NE:   r = {31'd0, a != b};
                BR_LT:   r = {31'd0, $signed(a) < $signed(b)};
                BR_GE:   r = {31'd0, $signed(a) >= $signed(b)};
                BR_LTU:  r = {31'd0, a < b};
                BR_GEU:  r = {31'd0, a >= b};
                default: r = '0;
            endcase
        end else if (typ == OPC_LUI) begin
            r = b;
        end
        return r;
    endfunction

endpackage

// File: rtl/alu_result_fifo.sv
// Result queue between the ALU stage and the CDB: flushable, pausable,
// head output reads as zero while empty.
module alu_result_fifo
    import arithmetic_logic_unit_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = ENTRY_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       flush,
    input  logic                       push,
    input  logic                       pop,
    input  logic [W-1:0]               din,
    output logic [W-1:0]               dout,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty,
    output logic                       full
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_push = en && !flush && push;
    assign do_pop  = en && !flush && pop && !empty;
    assign dout    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Upstream back-pressure leaves a slot for every accepted issue.
    assert property (@(posedge clk) disable iff (rst) !(do_push && full));

endmodule

// File: rtl/arithmetic_logic_unit.sv
// Single-stage ALU execution unit: one issue register (S1), combinational
// compute, and a result queue feeding the common data bus.
module arithmetic_logic_unit
    import arithmetic_logic_unit_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        _clear,
    input  logic        _alu_ready,
    input  logic [4:0]  _alu_rob_id,
    input  logic [6:0]  _alu_type,
    input  logic [3:0]  _alu_op,
    input  logic [31:0] _alu_v1,
    input  logic [31:0] _alu_v2,
    output logic        _alu_full,
    input  logic        _cdb_grant,
    output logic        _cdb_ready,
    output logic [4:0]  _cdb_rob_id,
    output logic [31:0] _cdb_value
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic               s1_valid;
    logic [4:0]         s1_rob_id;
    logic [6:0]         s1_type;
    logic [3:0]         s1_op;
    logic [31:0]        s1_v1;
    logic [31:0]        s1_v2;
    logic               accept;
    logic               pop;
    logic               empty;
    logic               fifo_full;
    logic [CW-1:0]      count;
    logic [ENTRY_W-1:0] push_data;
    logic [ENTRY_W-1:0] head;

    // Count the S1 entry too, so whatever is accepted can always be pushed.
    assign _alu_full = (32'(count) + 32'(s1_valid)) >= 32'(FIFO_DEPTH);
    assign accept    = rdy_in && _alu_ready && !_clear && !_alu_full;
    assign push_data = {s1_rob_id, alu_compute(s1_type, s1_op, s1_v1, s1_v2)};
    assign _cdb_ready  = rdy_in && !empty;
    assign pop         = _cdb_ready && _cdb_grant;
    assign _cdb_rob_id = head[ENTRY_W-1 -: ROB_W];
    assign _cdb_value  = head[XLEN-1:0];

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            s1_valid  <= 1'b0;
            s1_rob_id <= '0;
            s1_type   <= '0;
            s1_op     <= '0;
            s1_v1     <= '0;
            s1_v2     <= '0;
        end else if (_clear) begin
            s1_valid <= 1'b0;
        end else if (rdy_in) begin
            s1_valid <= accept;
            if (accept) begin
                s1_rob_id <= _alu_rob_id;
                s1_type   <= _alu_type;
                s1_op     <= _alu_op;
                s1_v1     <= _alu_v1;
                s1_v2     <= _alu_v2;
            end
        end
    end

    alu_result_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (ENTRY_W)
    ) u_fifo (
        .clk   (clk_in),
        .rst   (rst_in),
        .en    (rdy_in),
        .flush (_clear),
        .push  (s1_valid),
        .pop   (pop),
        .din   (push_data),
        .dout  (head),
        .count (count),
        .empty (empty),
        .full  (fifo_full)
    );

    logic unused_ok;
    assign unused_ok = fifo_full;

endmodule

// File: tb/tb_arithmetic_logic_unit.sv
// Directed-vector bench for the ALU execution unit and its result queue.
module tb_arithmetic_logic_unit;
    import arithmetic_logic_unit_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rdy = 1'b1;
    logic        clear = 1'b0;
    logic        alu_ready = 1'b0;
    logic [4:0]  rob = '0;
    logic [6:0]  ty = '0;
    logic [3:0]  op = '0;
    logic [31:0] v1 = '0;
    logic [31:0] v2 = '0;
    logic        alu_full;
    logic        grant = 1'b1;
    logic        cdb_ready;
    logic [4:0]  cdb_rob;
    logic [31:0] cdb_val;

    int n_run  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    arithmetic_logic_unit #(.FIFO_DEPTH(DEPTH)) dut (
        .clk_in      (clk),
        .rst_in      (rst),
        .rdy_in      (rdy),
        ._clear      (clear),
        ._alu_ready  (alu_ready),
        ._alu_rob_id (rob),
        ._alu_type   (ty),
        ._alu_op     (op),
        ._alu_v1     (v1),
        ._alu_v2     (v2),
        ._alu_full   (alu_full),
        ._cdb_grant  (grant),
        ._cdb_ready  (cdb_ready),
        ._cdb_rob_id (cdb_rob),
        ._cdb_value  (cdb_val)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [4:0] id, input logic [6:0] t,
                         input logic [3:0] o, input logic [31:0] a,
                         input logic [31:0] b);
        alu_ready = 1'b1;
        rob = id;
        ty  = t;
        op  = o;
        v1  = a;
        v2  = b;
    endtask

    // Issue one op with grant high; check it is absent after the issue edge
    // and present (tag and value) right after the following edge.
    task automatic run_op(input string tag, input logic [4:0] id,
                          input logic [6:0] t, input logic [3:0] o,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp);
        @(negedge clk);
        drive(id, t, o, a, b);
        @(negedge clk);
        alu_ready = 1'b0;
        check({tag, "/early"}, 32'(cdb_ready), 32'd0);
        @(negedge clk);
        check({tag, "/rdy"}, 32'(cdb_ready), 32'd1);
        check({tag, "/tag"}, 32'(cdb_rob), 32'(id));
        check({tag, "/val"}, cdb_val, exp);
    endtask

    initial begin
        int n;
        int stale;

        #3;
        check("rst/full", 32'(alu_full), 32'd0);
        check("rst/rdy", 32'(cdb_ready), 32'd0);
        check("rst/tag", 32'(cdb_rob), 32'd0);
        check("rst/val", cdb_val, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op("add", 5'd3, OPC_R, 4'b0000, 32'd5, 32'd7, 32'd12);
        run_op("slt", 5'd4, OPC_R, 4'b0010, 32'hFFFFFFFF, 32'd1, 32'd1);
        run_op("sltu", 5'd5, OPC_R, 4'b0011, 32'hFFFFFFFF, 32'd1, 32'd0);
        run_op("sra", 5'd6, OPC_R, 4'b1101, 32'h80000000, 32'd4, 32'hF8000000);
        run_op("srai", 5'd7, OPC_I, 4'b1101, 32'h80000000, 32'd4, 32'hF8000000);
        run_op("srli", 5'd8, OPC_I, 4'b0101, 32'h80000000, 32'd4, 32'h08000000);
        run_op("addi_b3", 5'd9, OPC_I, 4'b1000, 32'd10, 32'd3, 32'd13);
        run_op("sub_wrap", 5'd10, OPC_R, 4'b1000, 32'd0, 32'd1, 32'hFFFFFFFF);
        run_op("add_wrap", 5'd11, OPC_R, 4'b0000, 32'hFFFFFFFF, 32'd2, 32'd1);
        run_op("sll_amt", 5'd12, OPC_R, 4'b0001, 32'd1, 32'd33, 32'd2);
        run_op("xor", 5'd13, OPC_R, 4'b0100, 32'hF0F0, 32'h0FF0, 32'hFF00);
        run_op("or", 5'd14, OPC_R, 4'b0110, 32'hF000, 32'h000F, 32'hF00F);
        run_op("and", 5'd15, OPC_R, 4'b0111, 32'hFF0F, 32'h0FF0, 32'h0F00);
        run_op("blt", 5'd16, OPC_BRANCH, 4'b0100, 32'hFFFFFFFE, 32'd1, 32'd1);
        run_op("bgeu", 5'd17, OPC_BRANCH, 4'b0111, 32'hFFFFFFFE, 32'd1, 32'd1);
        run_op("bne", 5'd18, OPC_BRANCH, 4'b0001, 32'd9, 32'd9, 32'd0);
        run_op("bge", 5'd19, OPC_BRANCH, 4'b0101, 32'hFFFFFFFE, 32'd1, 32'd0);
        run_op("lui", 5'd20, OPC_LUI, 4'b0000, 32'd7, 32'h12345000, 32'h12345000);
        run_op("other", 5'd21, 7'b0000011, 4'b1000, 32'h100, 32'h20, 32'h120);

        // Back-pressure: issue whenever not full, grant held low.
        @(negedge clk);
        grant = 1'b0;
        n = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (!alu_full) begin
                drive(5'(10 + n), OPC_R, OP_ADD, 32'(n), 32'd0);
                n++;
            end else begin
                alu_ready = 1'b0;
            end
        end
        @(negedge clk);
        alu_ready = 1'b0;
        check("bp/accepts", 32'(n), 32'(DEPTH));
        check("bp/full", 32'(alu_full), 32'd1);
        grant = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            check("bp/rdy", 32'(cdb_ready), 32'd1);
            check("bp/tag", 32'(cdb_rob), 32'(10 + i));
            check("bp/val", cdb_val, 32'(i));
            if (i == 0)
                check("bp/full_hold", 32'(alu_full), 32'd1);
            if (i == 1)
                check("bp/full_drop", 32'(alu_full), 32'd0);
            @(negedge clk);
        end
        check("bp/drained", 32'(cdb_ready), 32'd0);

        // Flush: three queued, one in S1, one issued alongside clear.
        grant = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive(5'(20 + i), OPC_R, OP_ADD, 32'd1, 32'd1);
        end
        @(negedge clk);
        check("fl/full_pre", 32'(alu_full), 32'd1);
        drive(5'd24, OPC_R, OP_ADD, 32'd1, 32'd1);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        alu_ready = 1'b0;
        check("fl/rdy", 32'(cdb_ready), 32'd0);
        check("fl/full", 32'(alu_full), 32'd0);
        grant = 1'b1;
        stale = 0;
        repeat (4) begin
            @(negedge clk);
            if (cdb_ready) stale++;
        end
        check("fl/stale", 32'(stale), 32'd0);

        // Pause with one queued result and a pending issue that must be ignored.
        grant = 1'b0;
        @(negedge clk);
        drive(5'd7, OPC_R, OP_ADD, 32'd100, 32'd1);
        @(negedge clk);
        alu_ready = 1'b0;
        @(negedge clk);
        rdy = 1'b0;
        grant = 1'b1;
        drive(5'd8, OPC_R, OP_ADD, 32'd5, 32'd5);
        #1;
        check("ps/rdy_low", 32'(cdb_ready), 32'd0);
        repeat (5) begin
            @(negedge clk);
            check("ps/hold_rdy", 32'(cdb_ready), 32'd0);
            check("ps/hold_tag", 32'(cdb_rob), 32'd7);
        end
        alu_ready = 1'b0;
        rdy = 1'b1;
        #1;
        check("ps/resume_rdy", 32'(cdb_ready), 32'd1);
        check("ps/resume_tag", 32'(cdb_rob), 32'd7);
        check("ps/resume_val", cdb_val, 32'd101);
        @(negedge clk);
        check("ps/no_extra", 32'(cdb_ready), 32'd0);

        // Asynchronous reset between edges with a result queued.
        grant = 1'b0;
        drive(5'd5, OPC_R, OP_ADD, 32'd40, 32'd2);
        @(negedge clk);
        alu_ready = 1'b0;
        @(negedge clk);
        check("rs/pre_rdy", 32'(cdb_ready), 32'd1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("rs/rdy", 32'(cdb_ready), 32'd0);
        check("rs/tag", 32'(cdb_rob), 32'd0);
        check("rs/val", cdb_val, 32'd0);
        check("rs/full", 32'(alu_full), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        grant = 1'b1;
        drive(5'd6, OPC_R, OP_ADD, 32'd2, 32'd3);
        @(negedge clk);
        alu_ready = 1'b0;
        check("rs/early", 32'(cdb_ready), 32'd0);
        @(negedge clk);
        check("rs/first_rdy", 32'(cdb_ready), 32'd1);
        check("rs/first_tag", 32'(cdb_rob), 32'd6);
        check("rs/first_val", cdb_val, 32'd5);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/arithmetic_logic_unit.md
ARITHMETIC_LOGIC_UNIT -- requirements
Module: arithmetic_logic_unit

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, result-queue entries (power of two, >=2).
REQ-002 SHALL have ports:
- clk_in  input  1  system clock, one clock
- rst_in  input  1  reset, asynchronous, active-high
- rdy_in  input  1  pause; all state holds when low
- _clear  input  1  misprediction flush
- _alu_ready  input  1  issue valid from reservation station
- _alu_rob_id  input  5  destination ROB tag
- _alu_type  input  7  RV32I opcode
- _alu_op  input  4  {funct7[5], funct3}
- _alu_v1  input  32  operand 1
- _alu_v2  input  32  operand 2 or immediate
- _alu_full  output  1  back-pressure to reservation station
- _cdb_grant  input  1  CDB arbiter accepts this unit's broadcast
- _cdb_ready  output  1  result broadcast valid
- _cdb_rob_id  output  5  result tag
- _cdb_value  output  32  result value

Function
REQ-003 SHALL accept an issue on a rising edge when rdy_in && _alu_ready && !_clear, latching it into a single stage register (S1).
REQ-004 SHALL compute the S1 result combinationally and push {rob_id, result} into the result FIFO on the next enabled edge; S1 refills in that same edge, giving sustained throughput of 1/cycle.
REQ-005 SHALL use these types:
- 0110011 (R): op 0000 add, 1000 sub, 0001 sll, 0010 slt, 0011 sltu, 0100 xor, 0101 srl, 1101 sra, 0110 or, 0111 and.
- 0010011 (I): same as R, except op[3] is ignored for all ops other than op[2:0]=101.
- 1100011 (branch): result 1 if condition holds, else 0; op[2:0] 000 eq, 001 ne, 100 lt, 101 ge, 110 ltu, 111 geu.
- 0110111 (LUI): result = v2.
- Any other type: result = v1 + v2.
REQ-006 SHALL take shift amount = v2[4:0]; signed compares use two's complement; add/sub SHALL wrap modulo 2^32.
REQ-007 SHALL assert _alu_full = (fifo_count + S1_valid) >= FIFO_DEPTH, from registered state only, so an accepted issue always has a guaranteed slot.
REQ-008 SHALL drive _cdb_ready = rdy_in && fifo nonempty; _cdb_rob_id/_cdb_value SHALL show the FIFO head.
REQ-009 SHALL pop the head on an edge where _cdb_ready && _cdb_grant; a head without grant SHALL hold unchanged.
REQ-010 SHALL support push and pop in the same edge with count unchanged; pointers SHALL wrap modulo FIFO_DEPTH.
REQ-011 SHALL give minimum latency of one cycle: issue sampled at edge t gives _cdb_ready high after edge t+1, when the FIFO was empty.
REQ-012 SHALL, on a _clear edge, empty S1 and the FIFO and ignore the same-cycle issue; _clear SHALL take priority over rdy_in.
REQ-013 SHALL, when rdy_in is low, hold S1, FIFO and pointers and perform no accept, push or pop.
REQ-014 SHALL NOT push into the FIFO when it is full; REQ-007 makes this unreachable, and an assertion SHALL flag it.

Reset
REQ-015 SHALL, while rst_in is high, asynchronously clear S1_valid, FIFO count and pointers, so that _alu_full=0, _cdb_ready=0, _cdb_rob_id=0 and _cdb_value=0.
REQ-016 SHALL, when rst_in asserts mid-operation, discard in-flight results; the first accept SHALL be possible on the first edge after release.

Structure
REQ-017 SHALL place opcode constants (R, I, BRANCH, LUI) and op encodings in a shared package used by the decoder and reservation station.
REQ-018 SHALL use one sub-module, alu_result_fifo (parameterised depth, push/pop/count, async reset, flush).

Verification
REQ-019 R-type add: v1=5, v2=7, op=0000, rob_id=3, grant=1 -> _cdb_ready high one cycle later, value 12, rob_id 3.
REQ-020 Signed/unsigned: slt v1=0xFFFFFFFF, v2=1 -> 1; sltu same operands -> 0; sra 0x80000000 by 4 -> 0xF8000000; I-type srai op=1101 -> same result.
REQ-021 Branch: blt v1=-2, v2=1 -> 1; bgeu same operands -> 1; bne 9,9 -> 0.
REQ-022 Back-pressure: hold _cdb_grant=0 and issue every cycle -> exactly FIFO_DEPTH accepts, _alu_full high; then raise grant -> results emerge in issue order, full drops the cycle after the first pop.
REQ-023 Flush: 3 results queued plus one issue in the _clear cycle -> next cycle _cdb_ready=0, _alu_full=0, and no stale tag ever appears.
REQ-024 Pause/reset: rdy_in low for 5 cycles with a queued result -> _cdb_ready=0 and state held, then the result resumes intact; rst_in pulsed mid-stream between edges -> outputs 0 immediately.
